// File: rtl/tmboc_counter.sv
// tmboc_counter: Wishbone-mapped 32-bit programmable counter/timer with status pads and match interrupt
module tmboc_counter #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [37:0] io_out,
  output logic [37:0] io_oeb,
  output logic        irq_o
);
  logic [31:0] count, compare, rdata, next_count, count_wr, compare_wr;
  logic [15:0] prescale, pre;
  logic [5:0]  status_io;
  logic [3:0]  ctrl;
  logic [7:0]  off;
  logic        match, hit, acc, wr, wr_count, wr_ctrl, wr_cmp, wr_flags, wr_pre, wr_stat;
  logic        tick, at_match, set_match;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sel[i] ? d[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  assign off        = wbs_adr_i[7:0];
  assign hit        = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign acc        = hit & ~wbs_ack_o;
  assign wr         = acc & wbs_we_i;
  assign wr_count   = wr & (off == 8'h00);
  assign wr_ctrl    = wr & (off == 8'h04) & wbs_sel_i[0];
  assign wr_cmp     = wr & (off == 8'h08);
  assign wr_flags   = wr & (off == 8'h0C) & wbs_sel_i[0] & wbs_dat_i[0];
  assign wr_pre     = wr & (off == 8'h10);
  assign wr_stat    = wr & (off == 8'h14) & wbs_sel_i[0];
  assign count_wr   = merge(count, wbs_dat_i, wbs_sel_i);
  assign compare_wr = merge(compare, wbs_dat_i, wbs_sel_i);
  assign tick       = ctrl[0] & (pre == prescale);
  assign at_match   = ctrl[1] ? (count == 32'd0) : (count == compare);
  // a software COUNT write discards a coincident tick, including its match
  assign set_match  = tick & at_match & ~wr_count;
  assign next_count = ctrl[1] ? (at_match ? (ctrl[2] ? compare : 32'hFFFF_FFFF) : count - 32'd1)
                              : ((at_match & ctrl[2]) ? 32'd0 : count + 32'd1);
  assign io_out     = {status_io, 32'd0};
  assign io_oeb     = {6'd0, 32'hFFFF_FFFF};

  always_comb begin
    rdata = '0;
    case (off)
      8'h00:   rdata = count;
      8'h04:   rdata = {28'd0, ctrl};
      8'h08:   rdata = compare;
      8'h0C:   rdata = {31'd0, match};
      8'h10:   rdata = {16'd0, prescale};
      8'h14:   rdata = {26'd0, status_io};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      irq_o     <= 1'b0;
      count     <= '0;
      compare   <= '0;
      ctrl      <= '0;
      match     <= 1'b0;
      prescale  <= '0;
      pre       <= '0;
      status_io <= '0;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= (acc & ~wbs_we_i) ? rdata : '0;
      irq_o     <= match & ctrl[3];
      pre       <= (~ctrl[0] | tick | wr_count) ? 16'd0 : pre + 16'd1;
      count     <= wr_count ? count_wr : tick ? next_count : count;
      match     <= set_match ? 1'b1 : wr_flags ? 1'b0 : match;
      if (wr_ctrl) ctrl <= wbs_dat_i[3:0];
      if (wr_cmp) compare <= compare_wr;
      if (wr_pre) prescale <= {wbs_sel_i[1] ? wbs_dat_i[15:8] : prescale[15:8],
                               wbs_sel_i[0] ? wbs_dat_i[7:0] : prescale[7:0]};
      if (wr_stat) status_io <= wbs_dat_i[5:0];
    end
  end
endmodule

// File: tb/tb_tmboc_counter.sv
// tb_tmboc_counter: scoreboard bench for tmboc_counter against an edge-indexed behavioural model
module tb_tmboc_counter;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        wb_clk_i = 0, wb_rst_i = 1, stb = 0, cyc = 0, we = 0;
  logic [3:0]  sel = 0;
  logic [31:0] adr = 0, dat = 0;
  logic        wbs_ack_o, irq_o;
  logic [31:0] wbs_dat_o;
  logic [37:0] io_out, io_oeb;

  tmboc_counter #(.BASE_ADDR(BASE)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o), .io_out(io_out), .io_oeb(io_oeb), .irq_o(irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int cycle = 0;
  always @(posedge wb_clk_i) cycle <= cycle + 1;

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  typedef struct packed {logic rd; logic [31:0] d;} exp_t;
  exp_t q[$];

  // Model: register state valid after edge m_edge; ticks land on edges m_base + k*(PRESCALE+1)
  logic [31:0] m_count, m_cmp;
  logic [15:0] m_p;
  logic [5:0]  m_stat;
  logic [3:0]  m_ctrl;
  logic        m_match;
  int          m_base, m_edge, m_set_edge;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? d[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_count = 0; m_cmp = 0; m_p = 0; m_stat = 0; m_ctrl = 0; m_match = 0;
    m_base = cycle; m_edge = cycle; m_set_edge = -1;
  endtask

  task automatic advance(input int e);
    for (int j = m_edge + 1; j <= e; j++)
      if (m_ctrl[0] && ((j - m_base) % (int'(m_p) + 1)) == 0) begin
        if (!m_ctrl[1]) begin
          if (m_count == m_cmp) begin
            m_match = 1; m_set_edge = j;
            m_count = m_ctrl[2] ? 32'd0 : m_count + 32'd1;
          end else m_count = m_count + 32'd1;
        end else begin
          if (m_count == 0) begin
            m_match = 1; m_set_edge = j;
            m_count = m_ctrl[2] ? m_cmp : 32'hFFFF_FFFF;
          end else m_count = m_count - 32'd1;
        end
      end
    if (e > m_edge) m_edge = e;
  endtask

  function automatic logic [31:0] model_reg(input logic [7:0] off);
    case (off)
      8'h00:   return m_count;
      8'h04:   return {28'd0, m_ctrl};
      8'h08:   return m_cmp;
      8'h0C:   return {31'd0, m_match};
      8'h10:   return {16'd0, m_p};
      8'h14:   return {26'd0, m_stat};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s, input int w);
    logic [31:0] t;
    case (off)
      8'h00: begin advance(w - 1); m_count = merge(m_count, d, s); m_base = w; m_edge = w; end
      8'h04: begin
        advance(w);
        if (s[0]) begin
          if (!m_ctrl[0] && d[0]) m_base = w;
          m_ctrl = d[3:0];
        end
      end
      8'h08: begin advance(w); m_cmp = merge(m_cmp, d, s); end
      8'h0C: begin advance(w); if (s[0] && d[0] && m_set_edge != w) m_match = 0; end
      8'h10: begin advance(w); t = merge({16'd0, m_p}, d, s); m_p = t[15:0]; end
      8'h14: begin advance(w); if (s[0]) m_stat = d[5:0]; end
      default: advance(w);
    endcase
  endtask

  // Issue one access; the expected response is queued before the bus is driven
  task automatic access(input logic w, input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
    int r;
    bit got;
    @(posedge wb_clk_i); @(negedge wb_clk_i);
    r = cycle + 1;
    if (w) begin
      q.push_back({1'b0, 32'd0});
      model_write(off, d, s, r);
    end else begin
      advance(r - 1);
      q.push_back({1'b1, model_reg(off)});
    end
    stb = 1; cyc = 1; we = w; adr = BASE | {24'd0, off}; dat = d; sel = s;
    got = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) begin got = 1; chk("ack_edge", cycle, r); end
    end
    if (!got) begin n_cmp++; n_bad++; $display("FAIL ack_timeout: no ack for offset %h", off); end
    stb = 0; cyc = 0; we = 0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d); access(1, off, d, 4'hF); endtask
  task automatic rd(input logic [7:0] off); access(0, off, 32'd0, 4'h0); endtask

  task automatic check_outs();
    repeat (2) @(negedge wb_clk_i);
    chk("io_out", io_out, {m_stat, 32'd0});
    chk("io_oeb", io_oeb, 38'h00_FFFF_FFFF);
    chk("irq_o", irq_o, m_match & m_ctrl[3]);
  endtask

  always @(negedge wb_clk_i) begin
    exp_t e;
    if (!wb_rst_i) begin
      if (wbs_ack_o) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL unexpected_ack: got ack with nothing outstanding");
        end else begin
          e = q.pop_front();
          if (e.rd) chk("read_data", wbs_dat_o, e.d);
        end
      end else chk("idle_dat_zero", wbs_dat_o, 32'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit got;
    logic [31:0] v;
    repeat (3) @(negedge wb_clk_i);
    chk("reset_ack", wbs_ack_o, 0);
    chk("reset_irq", irq_o, 0);
    wb_rst_i = 0;
    model_reset();
    for (int i = 0; i <= 6; i++) rd(8'(4 * i));
    check_outs();

    wr(8'h14, 31); check_outs();
    wr(8'h14, 30); check_outs();
    wr(8'h14, 32'h20); check_outs();

    // up count with auto-reload through a match, interrupt masked
    wr(8'h08, 9); wr(8'h10, 0); wr(8'h00, 0); wr(8'h04, 32'h5);
    repeat (12) @(negedge wb_clk_i);
    wr(8'h04, 32'h4);
    rd(8'h00); rd(8'h0C); check_outs();
    wr(8'h04, 32'hC); check_outs();
    wr(8'h0C, 1); rd(8'h0C); check_outs();

    // down from 0 without reload, then up wrap
    wr(8'h00, 0); wr(8'h10, 3); wr(8'h04, 32'h3);
    repeat (2) @(negedge wb_clk_i);
    wr(8'h04, 32'h2);
    rd(8'h00); rd(8'h0C);
    wr(8'h0C, 1);
    wr(8'h00, 32'hFFFF_FFFF); wr(8'h08, 5); wr(8'h10, 0); wr(8'h04, 32'h1);
    wr(8'h04, 32'h0);
    rd(8'h00); rd(8'h0C);
    wr(8'h0C, 1);

    // prescaled counting, and a COUNT write landing exactly on a tick
    wr(8'h10, 3); wr(8'h08, 32'hFFFF); wr(8'h00, 100); wr(8'h04, 32'h1);
    repeat (5) @(negedge wb_clk_i); rd(8'h00);
    repeat (7) @(negedge wb_clk_i); rd(8'h00);
    @(negedge wb_clk_i);
    while (((cycle + 2 - m_base) % (int'(m_p) + 1)) != 0) @(negedge wb_clk_i);
    wr(8'h00, 32'h5000);
    rd(8'h00);
    wr(8'h04, 0); rd(8'h00);

    // outside the window: no ack, no effect
    @(posedge wb_clk_i); @(negedge wb_clk_i);
    stb = 1; cyc = 1; we = 1; adr = BASE + 32'h100; dat = 32'hDEAD_BEEF; sel = 4'hF;
    got = 0;
    repeat (4) begin @(posedge wb_clk_i); #1; if (wbs_ack_o) got = 1; end
    stb = 0; cyc = 0; we = 0;
    chk("no_ack_outside", got, 0);
    rd(8'h00);

    wr(8'h08, 32'h1122_3344);
    access(1, 8'h08, 32'hAABB_CCDD, 4'b0010);
    rd(8'h08);

    repeat (10) begin
      v = $urandom_range(0, 1) ? 32'hFFFF_FFF8 + $urandom_range(0, 7) : $urandom_range(0, 15);
      wr(8'h08, $urandom_range(0, 12));
      wr(8'h10, $urandom_range(0, 3));
      wr(8'h00, v);
      wr(8'h0C, 1);
      wr(8'h04, {28'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1});
      repeat ($urandom_range(0, 30)) @(negedge wb_clk_i);
      rd(8'h00);
      repeat ($urandom_range(0, 20)) @(negedge wb_clk_i);
      wr(8'h04, {28'd0, m_ctrl[3:1], 1'b0});
      rd(8'h00); rd(8'h0C); rd(8'h04);
      check_outs();
    end

    // asynchronous reset in the middle of a bus write
    wr(8'h14, 32'h15);
    @(negedge wb_clk_i);
    stb = 1; cyc = 1; we = 1; adr = BASE + 32'h14; dat = 32'h3F; sel = 4'hF;
    #2 wb_rst_i = 1;
    #1;
    chk("async_rst_io_out", io_out, 38'd0);
    chk("async_rst_ack", wbs_ack_o, 0);
    repeat (2) @(negedge wb_clk_i);
    stb = 0; cyc = 0; we = 0;
    q.delete();
    wb_rst_i = 0;
    model_reset();
    for (int i = 0; i <= 5; i++) rd(8'(4 * i));
    check_outs();

    repeat (3) @(negedge wb_clk_i);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
